// File: rtl/spi_display_pkg.sv
// Shared SPI display definitions: panel command bytes, FSM states
// and the address-window header byte lookup.
package spi_display_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;
  localparam logic [3:0] HDR_LEN   = 4'd11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP,
    DONE
  } state_t;

  function automatic logic is_cmd(input logic [3:0] idx);
    return (idx == 4'd0) || (idx == 4'd5) || (idx == 4'd10);
  endfunction

  function automatic logic [7:0] hdr_byte(
    input logic [3:0]  idx,
    input logic [15:0] x,
    input logic [15:0] ya,
    input logic [15:0] yb
  );
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      4'd0:    b = CMD_CASET;
      4'd1:    b = x[15:8];
      4'd2:    b = x[7:0];
      4'd3:    b = x[15:8];
      4'd4:    b = x[7:0];
      4'd5:    b = CMD_PASET;
      4'd6:    b = ya[15:8];
      4'd7:    b = ya[7:0];
      4'd8:    b = yb[15:8];
      4'd9:    b = yb[7:0];
      4'd10:   b = CMD_RAMWR;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// Byte shifter: load a byte, shift it out MSB first over 8 cycles.
// done marks the last bit cycle so the next byte can load seamlessly.
module spi_byte_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       sdo,
  output logic       busy,
  output logic       done
);

  logic [7:0] sreg;
  logic [2:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (load) begin
      sreg <= data;
      cnt  <= 3'd7;
      busy <= 1'b1;
    end else if (busy) begin
      sreg <= {sreg[6:0], 1'b0};
      cnt  <= cnt - 3'd1;
      if (cnt == 3'd0)
        busy <= 1'b0;
    end
  end

  assign sdo  = busy & sreg[7];
  assign done = busy & (cnt == 3'd0);

endmodule

// File: rtl/spi_vertical.sv
// Draws a vertical line on an SPI panel: column/page window, RAMWR, pixels.
// Define SPI_VERTICAL_SWAP_EN to accept Y1>Y2 by swapping the row bounds.
module spi_vertical
  import spi_display_pkg::*;
#(
  parameter int          DELAY = 20,
  parameter int          X     = 0,
  parameter int          Y1    = 0,
  parameter int          Y2    = 319,
  parameter logic [15:0] COLOR = 16'hFFFF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  output logic o_mosi,
  output logic o_dc,
  output logic o_cs,
  output logic o_done
);

`ifdef SPI_VERTICAL_SWAP_EN
  localparam int   YA = (Y1 > Y2) ? Y2 : Y1;
  localparam int   YB = (Y1 > Y2) ? Y1 : Y2;
  localparam logic OK = 1'b1;
`else
  localparam int   YA = Y1;
  localparam int   YB = Y2;
  localparam logic OK = (Y1 <= Y2);
`endif

  localparam logic [8:0]  NPIX  = 9'(YB - YA + 1);
  localparam logic [15:0] XW    = 16'(X);
  localparam logic [15:0] YAW   = 16'(YA);
  localparam logic [15:0] YBW   = 16'(YB);
  localparam logic [15:0] GLAST = 16'(DELAY - 1);

  state_t state, state_n;

  logic [3:0]  hdr;
  logic        lo;
  logic [8:0]  pix;
  logic        fin;
  logic        dc_q;
  logic [15:0] gcnt;

  logic        load, adv, clr;
  logic [7:0]  cur_byte;
  logic        cur_dc, last;
  logic        tx_sdo, tx_busy, tx_done;

  // Counters always point at the next byte to load.
  assign cur_byte = (hdr != HDR_LEN) ? hdr_byte(hdr, XW, YAW, YBW)
                  : (lo ? COLOR[7:0] : COLOR[15:8]);
  assign cur_dc   = (hdr != HDR_LEN) ? ~is_cmd(hdr) : 1'b1;
  assign last     = (hdr == HDR_LEN) && lo && (pix == NPIX - 9'd1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      hdr   <= '0;
      lo    <= 1'b0;
      pix   <= '0;
      fin   <= 1'b0;
      dc_q  <= 1'b0;
      gcnt  <= '0;
    end else begin
      state <= state_n;
      if (clr) begin
        hdr <= '0;
        lo  <= 1'b0;
        pix <= '0;
        fin <= 1'b0;
      end else if (adv) begin
        dc_q <= cur_dc;
        if (last)
          fin <= 1'b1;
        if (hdr != HDR_LEN)
          hdr <= hdr + 4'd1;
        else if (!lo)
          lo <= 1'b1;
        else begin
          lo  <= 1'b0;
          pix <= pix + 9'd1;
        end
      end
      if (state == GAP)
        gcnt <= gcnt + 16'd1;
      else
        gcnt <= '0;
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    adv     = 1'b0;
    clr     = 1'b0;
    o_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          clr     = 1'b1;
          state_n = OK ? LOAD : DONE;
        end
      end
      LOAD: begin
        load    = 1'b1;
        adv     = 1'b1;
        state_n = SHIFT;
      end
      SHIFT: begin
        if (tx_done) begin
          if (DELAY != 0)
            state_n = GAP;
          else if (fin)
            state_n = DONE;
          else begin
            load = 1'b1;
            adv  = 1'b1;
          end
        end
      end
      GAP: begin
        if (gcnt == GLAST) begin
          if (fin)
            state_n = DONE;
          else begin
            load    = 1'b1;
            adv     = 1'b1;
            state_n = SHIFT;
          end
        end
      end
      DONE: begin
        o_done  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  spi_byte_tx u_tx (
    .clk  (i_clk),
    .rst  (i_rst),
    .load (load),
    .data (cur_byte),
    .sdo  (tx_sdo),
    .busy (tx_busy),
    .done (tx_done)
  );

  assign o_cs   = ~tx_busy;
  assign o_mosi = tx_sdo;
  assign o_dc   = dc_q & tx_busy;

endmodule

// File: tb/tb_spi_vertical.sv
// Directed bench for spi_vertical: decodes the SPI stream of several
// configured instances and compares it with hand-derived byte sequences.
module tb_spi_vertical;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] st;
  logic [3:0] mosi, dc, cs, done;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] byte_q[$];
  logic       dcs_q[$];
  int tf, td, le, lg;

  spi_vertical #(.DELAY(20), .X(5), .Y1(5), .Y2(10)) u_a (
    .i_clk(clk), .i_rst(rst), .i_start(st[0]),
    .o_mosi(mosi[0]), .o_dc(dc[0]), .o_cs(cs[0]), .o_done(done[0])
  );

  spi_vertical #(.DELAY(20), .X(239), .Y1(7), .Y2(7),
                 .COLOR(16'hF81F)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(st[1]),
    .o_mosi(mosi[1]), .o_dc(dc[1]), .o_cs(cs[1]), .o_done(done[1])
  );

  spi_vertical #(.DELAY(0), .X(200), .Y1(258), .Y2(260),
                 .COLOR(16'h1234)) u_c (
    .i_clk(clk), .i_rst(rst), .i_start(st[2]),
    .o_mosi(mosi[2]), .o_dc(dc[2]), .o_cs(cs[2]), .o_done(done[2])
  );

  spi_vertical #(.DELAY(3), .X(5), .Y1(10), .Y2(5)) u_d (
    .i_clk(clk), .i_rst(rst), .i_start(st[3]),
    .o_mosi(mosi[3]), .o_dc(dc[3]), .o_cs(cs[3]), .o_done(done[3])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start on instance k and decode its stream until o_done.
  task automatic capture(input int k, input int gap, input int budget);
    int cyc = 0;
    int bitn = 0;
    int hi_run = 0;
    logic [7:0] sh = '0;
    logic dcb = 1'b0;
    bit started = 0;
    byte_q.delete();
    dcs_q.delete();
    tf = -1; td = -1; le = 0; lg = -1;
    @(negedge clk);
    st[k] = 1'b1;
    while (cyc < budget && td < 0) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) st[k] = 1'b0;
      if (done[k]) begin
        td = cyc;
        lg = hi_run;
        if (bitn != 0) le++;
      end else if (!cs[k]) begin
        if (started && bitn == 0 && hi_run != gap) le++;
        if (!started) begin
          started = 1;
          tf = cyc;
        end
        hi_run = 0;
        if (bitn == 0) dcb = dc[k];
        else if (dc[k] !== dcb) le++;
        sh = {sh[6:0], mosi[k]};
        bitn++;
        if (bitn == 8) begin
          byte_q.push_back(sh);
          dcs_q.push_back(dcb);
          bitn = 0;
        end
      end else begin
        if (bitn != 0) begin
          le++;
          bitn = 0;
        end
        if (mosi[k] !== 1'b0) le++;
        hi_run++;
      end
    end
  endtask

  task automatic verify(input string nm, input int delay, input int x,
                        input int ya, input int yb,
                        input logic [15:0] color);
    logic [15:0] xv, av, bv;
    logic [7:0] e[$];
    logic ec[$];
    int n, m;
    xv = 16'(x); av = 16'(ya); bv = 16'(yb);
    n = yb - ya + 1;
    e = '{8'h2A, xv[15:8], xv[7:0], xv[15:8], xv[7:0],
          8'h2B, av[15:8], av[7:0], bv[15:8], bv[7:0], 8'h2C};
    ec = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
           1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < n; i++) begin
      e.push_back(color[15:8]); ec.push_back(1'b1);
      e.push_back(color[7:0]);  ec.push_back(1'b1);
    end
    chk({nm, " nbytes"}, byte_q.size(), e.size());
    m = (byte_q.size() < e.size()) ? byte_q.size() : e.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s byte%0d", nm, i), byte_q[i], e[i]);
      chk($sformatf("%s dc%0d", nm, i), dcs_q[i], ec[i]);
    end
    chk({nm, " draw_cycles"}, td - tf, (11 + 2 * n) * (8 + delay));
    chk({nm, " shape"}, le, 0);
    chk({nm, " last_gap"}, lg, delay);
  endtask

  initial begin
    int w;
    int hi;
    logic seen;
    rst = 1'b1;
    st  = '0;
    repeat (3) @(negedge clk);
    chk("reset cs", cs, 4'hF);
    chk("reset dc", dc, 4'h0);
    chk("reset mosi", mosi, 4'h0);
    chk("reset done", done, 4'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    capture(0, 20, 2000);
    verify("a", 20, 5, 5, 10, 16'hFFFF);
    chk("a total_644", td - tf, 644);
    @(negedge clk);
    chk("a done_width", done[0], 1'b0);

    capture(1, 20, 1000);
    verify("b", 20, 239, 7, 7, 16'hF81F);
    chk("b 13bytes", byte_q.size(), 13);

    capture(2, 0, 1000);
    verify("c", 0, 200, 258, 260, 16'h1234);
    st[2] = 1'b1;
    @(negedge clk);
    st[2] = 1'b0;
    chk("c done_width", done[2], 1'b0);
    hi = 0;
    repeat (30) begin
      @(negedge clk);
      if (cs[2] && !done[2]) hi++;
    end
    chk("c start_in_done_ignored", hi, 30);

    capture(3, 3, 1000);
`ifdef SPI_VERTICAL_SWAP_EN
    verify("d", 3, 5, 5, 10, 16'hFFFF);
`else
    chk("d nbytes", byte_q.size(), 0);
    chk("d no_cs", tf, 32'hFFFF_FFFF);
    chk("d done_cycle", td, 1);
`endif

    // Abort mid-pixel-phase with reset.
    @(negedge clk);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (400) @(negedge clk);
    w = 0;
    while (cs[0] && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("rst mid_draw_active", cs[0], 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst cs", cs[0], 1'b1);
    chk("rst dc", dc[0], 1'b0);
    chk("rst mosi", mosi[0], 1'b0);
    chk("rst done", done[0], 1'b0);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= done[0];
    end
    rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen |= done[0] | ~cs[0];
    end
    chk("rst no_done_after_abort", seen, 1'b0);

    // Restart with a stray second start in the middle of the draw.
    fork
      capture(0, 20, 2000);
      begin
        repeat (150) @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
      end
    join
    verify("a2", 20, 5, 5, 10, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
